// File: rtl/mips_mc_seq.sv
// Multi-cycle MIPS instruction sequencer: IF/ID/EX/MEM/WB control FSM with
// parametrised instruction/data memory wait counters and an external stall.
// State, wait counter and sticky illegal flag are registered; the datapath
// strobes and next-PC select are decoded combinationally from the state.
module mips_mc_seq #(
  parameter int IM_LAT = 1,
  parameter int DM_LAT = 1,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       stall,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       mem_wr,
  output logic [1:0] npc_sel,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ALU  = 4'd0,  // addu, subu, ori, lui: execute then write back
    C_LW   = 4'd1,
    C_SW   = 4'd2,
    C_BEQ  = 4'd3,
    C_J    = 4'd4,
    C_JAL  = 4'd5,
    C_JR   = 4'd6,
    C_ILL  = 4'd7
  } cls_t;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [CNT_W-1:0] IM_LAST = CNT_W'(IM_LAT - 1);
  localparam logic [CNT_W-1:0] DM_LAST = CNT_W'(DM_LAT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal;

  cls_t       w_cls;
  logic       w_pc_wr;
  logic       w_ir_wr;
  logic       w_reg_wr;
  logic       w_mem_wr;
  logic       w_done;
  logic [1:0] w_npc_sel;

  // Instruction class decode from opcode/funct
  always_comb begin
    w_cls = C_ILL;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: w_cls = C_ALU;   // addu
          6'b100011: w_cls = C_ALU;   // subu
          6'b001000: w_cls = C_JR;
          default:   w_cls = C_ILL;
        endcase
      end
      6'b001101: w_cls = C_ALU;       // ori
      6'b001111: w_cls = C_ALU;       // lui
      6'b100011: w_cls = C_LW;
      6'b101011: w_cls = C_SW;
      6'b000100: w_cls = C_BEQ;
      6'b000010: w_cls = C_J;
      6'b000011: w_cls = C_JAL;
      default:   w_cls = C_ILL;
    endcase
  end

  // Sequencer state, wait counter and sticky illegal flag; stall freezes all
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IF;
      r_cnt     <= {CNT_W{1'b0}};
      r_illegal <= 1'b0;
    end else if (!stall) begin
      case (r_state)
        S_IF: begin
          if (r_cnt == IM_LAST) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= S_ID;
          end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_ID: begin
          r_cnt <= {CNT_W{1'b0}};
          case (w_cls)
            C_ILL: begin
              r_illegal <= 1'b1;
              r_state   <= S_HALT;
            end
            C_J, C_JAL: r_state <= S_IF;
            default:    r_state <= S_EX;
          endcase
        end
        S_EX: begin
          r_cnt <= {CNT_W{1'b0}};
          case (w_cls)
            C_ALU:      r_state <= S_WB;
            C_LW, C_SW: r_state <= S_MEM;
            default:    r_state <= S_IF;  // beq / jr complete here
          endcase
        end
        S_MEM: begin
          if (r_cnt == DM_LAST) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= (w_cls == C_LW) ? S_WB : S_IF;
          end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_WB: begin
          r_cnt   <= {CNT_W{1'b0}};
          r_state <= S_IF;
        end
        S_HALT: begin
          r_cnt   <= {CNT_W{1'b0}};
          r_state <= S_HALT;
        end
        default: begin
          r_cnt   <= {CNT_W{1'b0}};
          r_state <= S_IF;
        end
      endcase
    end
  end

  // Unstalled strobe / next-PC decode from current state and instruction class
  always_comb begin
    w_pc_wr   = 1'b0;
    w_ir_wr   = 1'b0;
    w_reg_wr  = 1'b0;
    w_mem_wr  = 1'b0;
    w_done    = 1'b0;
    w_npc_sel = NPC_PC4;
    if (rst) begin
      w_npc_sel = NPC_PC4;
    end else begin
      case (r_state)
        S_IF: begin
          if (r_cnt == IM_LAST) begin
            w_ir_wr = 1'b1;
            w_pc_wr = 1'b1;
          end else begin
            w_ir_wr = 1'b0;
          end
        end
        S_ID: begin
          if (w_cls == C_J || w_cls == C_JAL) begin
            w_pc_wr   = 1'b1;
            w_npc_sel = NPC_J;
            w_done    = 1'b1;
            w_reg_wr  = (w_cls == C_JAL);  // $31 <- PC+4
          end else begin
            w_pc_wr = 1'b0;
          end
        end
        S_EX: begin
          if (w_cls == C_JR) begin
            w_pc_wr   = 1'b1;
            w_npc_sel = NPC_JR;
            w_done    = 1'b1;
          end else if (w_cls == C_BEQ) begin
            w_pc_wr   = zero;
            w_npc_sel = NPC_BR;
            w_done    = 1'b1;
          end else begin
            w_pc_wr = 1'b0;
          end
        end
        S_MEM: begin
          if (r_cnt == DM_LAST && w_cls == C_SW) begin
            w_mem_wr = 1'b1;
            w_done   = 1'b1;
          end else begin
            w_mem_wr = 1'b0;
          end
        end
        S_WB: begin
          w_reg_wr = 1'b1;
          w_done   = 1'b1;
        end
        default: begin
          w_pc_wr = 1'b0;  // HALT and unused encodings drive nothing
        end
      endcase
    end
  end

  // Output drive: stall suppresses strobes and done but keeps npc_sel visible
  always_comb begin
    npc_sel = w_npc_sel;
    state   = r_state;
    illegal = r_illegal;
    if (stall) begin
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      reg_wr     = 1'b0;
      mem_wr     = 1'b0;
      instr_done = 1'b0;
    end else begin
      pc_wr      = w_pc_wr;
      ir_wr      = w_ir_wr;
      reg_wr     = w_reg_wr;
      mem_wr     = w_mem_wr;
      instr_done = w_done;
    end
  end

endmodule
